// File: rtl/alu_result_tx_pkg.sv
// Shared types and constants for the ALU result return path (frame format, FSM states).
package alu_result_tx_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned IDX_W     = 2;

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    // Bit positions inside the flags byte
    localparam int unsigned FLAG_OVF  = 1;
    localparam int unsigned FLAG_ZERO = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } tx_state_e;

    // Snapshot of the ALU outputs taken when a frame is accepted
    typedef struct packed {
        logic [BYTE_W-1:0] result;
        logic              overflow;
        logic              zero;
    } alu_snap_t;

    // Frame byte selector: header, result, flags, xor checksum of the first three
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] header,
        input alu_snap_t         snap
    );
        logic [BYTE_W-1:0] flags;
        flags            = '0;
        flags[FLAG_OVF]  = snap.overflow;
        flags[FLAG_ZERO] = snap.zero;
        case (idx)
            2'd0:    frame_byte = header;
            2'd1:    frame_byte = snap.result;
            2'd2:    frame_byte = flags;
            default: frame_byte = header ^ snap.result ^ flags;
        endcase
    endfunction

endpackage

// File: rtl/alu_result_tx_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module alu_result_tx_watchdog #(
    parameter int unsigned TIMEOUT    = 150000,
    parameter int unsigned NB_TIMEOUT = 18
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT - 1);

    logic [NB_TIMEOUT-1:0] r_count;

    // Cycle counter: clear has priority over enable
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + NB_TIMEOUT'(1);
        end
    end

    assign o_expired_c = (r_count == LAST_COUNT);

endmodule

// File: rtl/alu_result_tx.sv
// Sends a 4-byte frame {header, result, flags, checksum} of a snapshotted ALU result to the UART TX.
module alu_result_tx
    import alu_result_tx_pkg::*;
#(
    parameter int unsigned       NB_DATA    = 8,
    parameter int unsigned       NB_BYTE    = BYTE_W,
    parameter logic [BYTE_W-1:0] HEADER     = HEADER_DEFAULT,
    parameter int unsigned       TIMEOUT    = 150000,
    parameter int unsigned       NB_TIMEOUT = 18
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_send,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_overflow,
    input  logic               i_zero,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    tx_state_e          r_state;
    logic [IDX_W-1:0]   r_index;
    alu_snap_t          r_snap;
    logic               r_tx_start;
    logic [NB_BYTE-1:0] r_tx_data;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_error;

    alu_snap_t          w_snap_in;
    logic               w_wd_clear;
    logic               w_wd_enable;
    logic               w_wd_expired;

    // Live ALU outputs packed for capture; the result is zero-extended into its byte
    always_comb begin
        w_snap_in          = '0;
        w_snap_in.result   = BYTE_W'(i_result);
        w_snap_in.overflow = i_overflow;
        w_snap_in.zero     = i_zero;
    end

    // Watchdog restarts with every byte and only runs while waiting for an ack
    assign w_wd_clear  = (r_state == ST_SEND);
    assign w_wd_enable = (r_state == ST_WAIT) && !i_tx_done && !w_wd_expired;

    alu_result_tx_watchdog #(
        .TIMEOUT    (TIMEOUT),
        .NB_TIMEOUT (NB_TIMEOUT)
    ) u_watchdog (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clear     (w_wd_clear),
        .i_enable    (w_wd_enable),
        .o_expired_c (w_wd_expired)
    );

    // Frame FSM; outputs are set on the edge that enters the state they belong to
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_snap       <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_send) begin
                        r_snap     <= w_snap_in;
                        r_index    <= '0;
                        r_state    <= ST_SEND;
                        r_busy     <= 1'b1;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= NB_BYTE'(frame_byte(IDX_W'(0), HEADER, w_snap_in));
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (r_index == LAST_IDX) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_index    <= r_index + IDX_W'(1);
                            r_state    <= ST_SEND;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= NB_BYTE'(frame_byte(r_index + IDX_W'(1), HEADER, r_snap));
                        end
                    end else if (w_wd_expired) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_alu_result_tx.sv
// Testbench for alu_result_tx: randomized frames checked against a byte-level frame model.
module tb_alu_result_tx;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic       i_send;
    logic [7:0] i_result;
    logic       i_overflow;
    logic       i_zero;
    logic       i_tx_done;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_error;

    int checks = 0;
    int errors = 0;

    // Observations collected by the monitor
    int         cyc = 0;
    logic [7:0] q_data[$];
    int         q_cyc[$];
    int         n_done = 0;
    int         n_err = 0;
    int         done_cyc = -1;
    int         err_cyc = -1;

    alu_result_tx #(
        .NB_DATA    (8),
        .NB_BYTE    (8),
        .HEADER     (8'hA5),
        .TIMEOUT    (TO),
        .NB_TIMEOUT (18)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_send       (i_send),
        .i_result     (i_result),
        .i_overflow   (i_overflow),
        .i_zero       (i_zero),
        .i_tx_done    (i_tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    // Monitor: sample just after each rising edge, numbering cycles by edge count
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (o_tx_start === 1'b1) begin
            q_data.push_back(o_tx_data);
            q_cyc.push_back(cyc);
        end
        if (o_frame_done === 1'b1) begin
            n_done = n_done + 1;
            done_cyc = cyc;
        end
        if (o_error === 1'b1) begin
            n_err = n_err + 1;
            err_cyc = cyc;
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout sim did not finish, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_cyc.delete();
        n_done = 0;
        n_err = 0;
        done_cyc = -1;
        err_cyc = -1;
    endtask

    // Reference frame built from the frame definition
    function automatic void model_frame(input logic [7:0] r, input logic ovf, input logic zero,
                                        output logic [7:0] exp_b [4]);
        exp_b[0] = 8'hA5;
        exp_b[1] = r;
        exp_b[2] = {6'b000000, ovf, zero};
        exp_b[3] = exp_b[0] ^ exp_b[1] ^ exp_b[2];
    endfunction

    // Host/UART stand-in: request a frame, ack each start after 'delay' cycles.
    // stall_byte >= 0 withholds the ack for that byte and waits for the abort.
    task automatic drive_frame(input logic [7:0] res, input logic ovf, input logic zero,
                               input int delay, input int stall_byte, input bit poke_send,
                               input bit mid_change, input bit send_glitch,
                               output int send_cyc, output bit timed_out);
        int guard;
        timed_out = 1'b0;
        i_result = res; i_overflow = ovf; i_zero = zero;
        i_send = 1'b1; send_cyc = cyc;
        tick();
        i_send = 1'b0;
        for (int b = 0; b < 4; b++) begin
            guard = 0;
            while (o_tx_start !== 1'b1 && guard < 100) begin tick(); guard++; end
            if (o_tx_start !== 1'b1) begin timed_out = 1'b1; return; end
            if (b == 0 && mid_change) begin
                i_result = res ^ 8'h55; i_overflow = ~ovf; i_zero = ~zero;
            end
            if (b == stall_byte) begin
                guard = 0;
                while (o_error !== 1'b1 && guard < TO + 20) begin tick(); guard++; end
                if (o_error !== 1'b1) timed_out = 1'b1;
                return;
            end
            for (int t = 0; t < delay; t++) begin
                i_send    = poke_send && (b == 1) && (t == 1);
                i_tx_done = send_glitch && (t == 0);
                tick();
            end
            i_send = 1'b0; i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        guard = 0;
        while (o_frame_done !== 1'b1 && guard < 20) begin tick(); guard++; end
        if (o_frame_done !== 1'b1) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_send = 1'b0; i_result = 8'h00; i_overflow = 1'b0;
        i_zero = 1'b0; i_tx_done = 1'b0;
        tick(); tick(); tick();
        checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", o_tx_start); end
        checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", o_tx_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", o_frame_done); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", o_error); end
        i_reset_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_fixed_frame();
        logic [7:0] exp_c [4];
        int sc; bit to;
        exp_c[0] = 8'hA5; exp_c[1] = 8'h7F; exp_c[2] = 8'h02; exp_c[3] = 8'hD8;
        clear_obs();
        drive_frame(8'h7F, 1'b1, 1'b0, 10, -1, 1'b0, 1'b0, 1'b0, sc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL fixed_timeout bound expired"); end
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL fixed_nbytes got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_c[i]) begin errors++; $display("FAIL fixed_byte%0d got %h exp %h", i, q_data[i], exp_c[i]); end
        end
        if (q_cyc.size() == 4) begin
            checks++; if (q_cyc[0] != sc + 1) begin errors++; $display("FAIL fixed_hdr_latency got %0d exp %0d", q_cyc[0], sc + 1); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (q_cyc[i+1] - q_cyc[i] != 11) begin errors++; $display("FAIL fixed_spacing%0d got %0d exp 11", i, q_cyc[i+1] - q_cyc[i]); end
            end
            checks++; if (done_cyc != q_cyc[3] + 11) begin errors++; $display("FAIL fixed_done_cycle got %0d exp %0d", done_cyc, q_cyc[3] + 11); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL fixed_ndone got %0d exp 1", n_done); end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL fixed_busy_after got %b exp 0", o_busy); end
        checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL fixed_done_width got %b exp 0", o_frame_done); end
        tick();
    endtask

    task automatic test_random_frames();
        logic [7:0] exp_b [4];
        logic [7:0] r; logic ov, zr;
        int d, sc; bit to;
        for (int n = 0; n < 8; n++) begin
            r = 8'($urandom); ov = 1'($urandom); zr = 1'($urandom);
            d = int'($urandom_range(1, 12));
            model_frame(r, ov, zr, exp_b);
            clear_obs();
            drive_frame(r, ov, zr, d, -1, 1'b0, 1'b0, 1'b0, sc, to);
            checks++; if (to !== 1'b0 || q_data.size() != 4) begin errors++; $display("FAIL rand%0d_nbytes got %0d exp 4 (timeout=%b)", n, q_data.size(), to); end
            for (int i = 0; i < 4 && i < q_data.size(); i++) begin
                checks++; if (q_data[i] !== exp_b[i]) begin errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", n, i, q_data[i], exp_b[i]); end
            end
            if (q_cyc.size() == 4) begin
                checks++; if (done_cyc != q_cyc[3] + d + 1) begin errors++; $display("FAIL rand%0d_done_cycle got %0d exp %0d", n, done_cyc, q_cyc[3] + d + 1); end
            end
            checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL rand%0d_pulses done=%0d err=%0d exp 1/0", n, n_done, n_err); end
            tick();
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] exp_c [4];
        int sc; bit to;
        exp_c[0] = 8'hA5; exp_c[1] = 8'h00; exp_c[2] = 8'h01; exp_c[3] = 8'hA4;
        clear_obs();
        drive_frame(8'h00, 1'b0, 1'b1, 4, -1, 1'b0, 1'b1, 1'b0, sc, to);
        checks++; if (to !== 1'b0 || q_data.size() != 4) begin errors++; $display("FAIL snap_nbytes got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_c[i]) begin errors++; $display("FAIL snap_byte%0d got %h exp %h", i, q_data[i], exp_c[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [4];
        logic [7:0] r;
        int sc; bit to;
        r = 8'($urandom);
        model_frame(r, 1'b1, 1'b1, exp_b);
        clear_obs();
        drive_frame(r, 1'b1, 1'b1, 5, -1, 1'b1, 1'b0, 1'b0, sc, to);
        // now in the DONE cycle: a request here must be dropped
        i_send = 1'b1;
        tick();
        i_send = 1'b0;
        repeat (15) tick();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout bound expired"); end
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL b2b_nstarts got %0d exp 4", q_data.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL b2b_ndone got %0d exp 1", n_done); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, q_data[i], exp_b[i]); end
        end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle got %b exp 0", o_busy); end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_b [4];
        logic [7:0] r;
        int sc; bit to;
        r = 8'($urandom);
        model_frame(r, 1'b0, 1'b0, exp_b);
        clear_obs();
        drive_frame(r, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0, 1'b0, sc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL to_no_error bound expired"); end
        checks++; if (q_data.size() != 2) begin errors++; $display("FAIL to_nbytes got %0d exp 2", q_data.size()); end
        for (int i = 0; i < 2 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_b[i]) begin errors++; $display("FAIL to_byte%0d got %h exp %h", i, q_data[i], exp_b[i]); end
        end
        if (q_cyc.size() == 2) begin
            checks++; if (err_cyc != q_cyc[1] + 1 + TO) begin errors++; $display("FAIL to_err_cycle got %0d exp %0d", err_cyc, q_cyc[1] + 1 + TO); end
        end
        checks++; if (n_err != 1 || n_done != 0) begin errors++; $display("FAIL to_pulses err=%0d done=%0d exp 1/0", n_err, n_done); end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL to_busy_after got %b exp 0", o_busy); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL to_err_width got %b exp 0", o_error); end
        r = 8'($urandom);
        model_frame(r, 1'b1, 1'b0, exp_b);
        clear_obs();
        drive_frame(r, 1'b1, 1'b0, 2, -1, 1'b0, 1'b0, 1'b0, sc, to);
        checks++; if (to !== 1'b0 || q_data.size() != 4) begin errors++; $display("FAIL to_restart_nbytes got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_b[i]) begin errors++; $display("FAIL to_restart_byte%0d got %h exp %h", i, q_data[i], exp_b[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [4];
        logic [7:0] r;
        int sc; bit to;
        r = 8'($urandom);
        clear_obs();
        i_result = r; i_overflow = 1'b1; i_zero = 1'b0;
        i_send = 1'b1; tick(); i_send = 1'b0;
        tick(); i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        tick(); i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        tick();
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b exp 1", o_busy); end
        i_reset_n = 1'b0;
        tick();
        checks++; if (q_data.size() != 3) begin errors++; $display("FAIL rst_nbytes got %0d exp 3", q_data.size()); end
        checks++; if ({o_tx_start, o_tx_data, o_busy, o_frame_done, o_error} !== 12'h000)
            begin errors++; $display("FAIL rst_outputs got start=%b data=%h busy=%b done=%b err=%b exp all 0", o_tx_start, o_tx_data, o_busy, o_frame_done, o_error); end
        i_reset_n = 1'b1;
        tick(); tick();
        checks++; if (n_done != 0 || n_err != 0) begin errors++; $display("FAIL rst_pulses done=%0d err=%0d exp 0/0", n_done, n_err); end
        r = 8'($urandom);
        model_frame(r, 1'b0, 1'b1, exp_b);
        clear_obs();
        drive_frame(r, 1'b0, 1'b1, 3, -1, 1'b0, 1'b0, 1'b0, sc, to);
        checks++; if (to !== 1'b0 || q_data.size() != 4) begin errors++; $display("FAIL rst_fresh_nbytes got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_b[i]) begin errors++; $display("FAIL rst_fresh_byte%0d got %h exp %h", i, q_data[i], exp_b[i]); end
        end
        tick();
    endtask

    task automatic test_stray_done();
        logic [7:0] exp_b [4];
        logic [7:0] r;
        int sc; bit to;
        clear_obs();
        i_tx_done = 1'b1; repeat (3) tick(); i_tx_done = 1'b0;
        repeat (3) tick();
        checks++; if (q_data.size() != 0 || o_busy !== 1'b0) begin errors++; $display("FAIL idle_done starts=%0d busy=%b exp 0/0", q_data.size(), o_busy); end
        // ack pulse during each SEND cycle must be ignored
        r = 8'($urandom);
        model_frame(r, 1'b1, 1'b1, exp_b);
        clear_obs();
        drive_frame(r, 1'b1, 1'b1, 3, -1, 1'b0, 1'b0, 1'b1, sc, to);
        checks++; if (to !== 1'b0 || q_data.size() != 4) begin errors++; $display("FAIL send_done_nbytes got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_b[i]) begin errors++; $display("FAIL send_done_byte%0d got %h exp %h", i, q_data[i], exp_b[i]); end
        end
        for (int i = 0; i < 3 && q_cyc.size() == 4; i++) begin
            checks++; if (q_cyc[i+1] - q_cyc[i] != 4) begin errors++; $display("FAIL send_done_spacing%0d got %0d exp 4", i, q_cyc[i+1] - q_cyc[i]); end
        end
        tick();
        // immediate acks give the shortest frame
        r = 8'($urandom);
        clear_obs();
        drive_frame(r, 1'b0, 1'b0, 1, -1, 1'b0, 1'b0, 1'b0, sc, to);
        checks++; if (to !== 1'b0 || q_cyc.size() != 4) begin errors++; $display("FAIL minframe_nbytes got %0d exp 4", q_cyc.size()); end
        if (q_cyc.size() == 4) begin
            checks++; if (done_cyc - q_cyc[0] + 1 != 9) begin errors++; $display("FAIL minframe_len got %0d exp 9", done_cyc - q_cyc[0] + 1); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_random_frames();
        test_snapshot();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_stray_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_tx.md
Name: alu_result_tx

Overview:
Reads the ALU result and flags back out of the design and returns them to the host over the team's UART transmitter. This is the return direction to the operand/opcode loading path.
On a send request, the block snapshots the result, overflow and zero flags. It then emits a fixed 4-byte frame (header, result, flags, checksum) one byte at a time, using a start/done byte handshake with the UART TX.
A watchdog aborts the frame if the transmitter stalls.

Parameters:
NB_DATA, 8, ALU result width; must be 1..8; zero-extended into the result byte
NB_BYTE, 8, UART byte width (fixed 8)
HEADER, 8'hA5, frame header byte
TIMEOUT, 150000, max cycles in WAIT without i_tx_done before abort (≥ one byte time at 9600 baud / 100 MHz)
NB_TIMEOUT, 18, watchdog counter width; 2**NB_TIMEOUT > TIMEOUT

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset_n  in  1  synchronous reset, active-low
i_send  in  1  send request pulse; sampled only in IDLE
i_result  in  NB_DATA  ALU result
i_overflow  in  1  ALU overflow flag
i_zero  in  1  ALU zero flag
i_tx_done  in  1  UART TX 1-cycle pulse: current byte fully sent
o_tx_start  out  1  1-cycle pulse: load o_tx_data into UART TX
o_tx_data  out  NB_BYTE  byte to transmit; stable from start pulse until next start
o_busy  out  1  high whenever state != IDLE
o_frame_done  out  1  1-cycle pulse after last byte acknowledged
o_error  out  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (i_reset_n=0 at an edge): state=IDLE, byte index=0, snapshot regs=0, watchdog=0. Outputs: o_tx_start=0, o_tx_data=0, o_busy=0, o_frame_done=0, o_error=0. Reset mid-frame aborts immediately; no done/error pulse is generated.
- All outputs are registered.
- States: IDLE, SEND, WAIT, DONE, ERR.
- IDLE: if i_send=1, capture {i_result zero-extended to 8b, i_overflow, i_zero}, set index=0, go to SEND. i_tx_done is ignored in IDLE.
- SEND (1 cycle): o_tx_start=1; o_tx_data=byte[index]; clear watchdog; go to WAIT.
- Frame bytes:
  - byte0 = HEADER
  - byte1 = result
  - byte2 = {6'b0, overflow, zero}
  - byte3 = byte0 ^ byte1 ^ byte2
- WAIT:
  - If i_tx_done=1: when index==3 go to DONE; otherwise index+1 and go to SEND.
  - Else if watchdog==TIMEOUT-1: go to ERR.
  - Else watchdog+1.
- DONE (1 cycle): o_frame_done=1, then IDLE. ERR (1 cycle): o_error=1, then IDLE.
- Latency:
  - i_send sampled at edge k gives the header start pulse in cycle k+1.
  - i_tx_done sampled at edge j gives the next start pulse in cycle j+1.
  - Minimum frame length is 4×(SEND+WAIT) + DONE = 9 cycles.
- i_send while busy is ignored; it is not queued.
- Inputs changing mid-frame do not affect the frame, because the snapshot is used.
- i_tx_done coinciding with the SEND cycle is ignored; only WAIT consumes it.
- An i_send in the same cycle the FSM returns to IDLE (DONE/ERR cycle) is ignored. The first accepted request is in the IDLE cycle.

Decomposition:
- Shared package: state encoding localparams (IDLE..ERR), FRAME_LEN=4, default HEADER, flags-byte bit positions (OVF=1, ZERO=0).
- One sub-module is natural: tx_watchdog (clear/enable/expire counter, parameterised by TIMEOUT and NB_TIMEOUT), reusable by the UART RX path.
- Frame byte mux and checksum stay inline.

Test Plan:
- i_result=8'h7F, ovf=1, zero=0, i_send pulse; bench acks each start after 10 cycles → bytes A5, 7F, 02, D8 in order; o_frame_done 1 cycle after the 4th ack; o_busy low afterwards.
- i_result=8'h00, ovf=0, zero=1 → A5, 00, 01, A4. Change i_result to 8'h55 after the first start → frame unchanged.
- Second i_send during byte1 WAIT → ignored: exactly 4 start pulses, one o_frame_done.
- TIMEOUT=50 override; bench never acks byte1 → o_error pulse exactly 50 cycles after the WAIT entry for byte1; no o_frame_done; o_busy=0 next cycle; a new i_send restarts at header A5.
- i_reset_n=0 during byte2 WAIT → next cycle all outputs 0, state IDLE. A following i_send sends a full fresh frame from A5.
- i_tx_done pulses in IDLE and during a SEND cycle → no state change and no extra bytes; acks immediately in the first WAIT cycle → 9-cycle frame.
